// File: rtl/pipe_ctrl_pkg.sv
// Shared decode constants and the control bundle carried from decode into execute.
package pipe_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_COP0  = 6'h10;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL   = 6'h00;
  localparam logic [5:0] F_SRL   = 6'h02;
  localparam logic [5:0] F_SRA   = 6'h03;
  localparam logic [5:0] F_SLLV  = 6'h04;
  localparam logic [5:0] F_SRLV  = 6'h06;
  localparam logic [5:0] F_SRAV  = 6'h07;
  localparam logic [5:0] F_JR    = 6'h08;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUBU  = 6'h23;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_XOR   = 6'h26;
  localparam logic [5:0] F_NOR   = 6'h27;
  localparam logic [5:0] F_SLT   = 6'h2A;
  localparam logic [5:0] F_SLTU  = 6'h2B;
  localparam logic [5:0] F_ERET  = 6'h18;

  // rs field selects the CP0 operation
  localparam logic [4:0] RS_MF = 5'h00;
  localparam logic [4:0] RS_MT = 5'h04;
  localparam logic [4:0] RS_CO = 5'h10;

  localparam logic [4:0] ALU_ADDU = 5'd0;
  localparam logic [4:0] ALU_SUBU = 5'd1;
  localparam logic [4:0] ALU_SLT  = 5'd2;
  localparam logic [4:0] ALU_AND  = 5'd3;
  localparam logic [4:0] ALU_NOR  = 5'd4;
  localparam logic [4:0] ALU_OR   = 5'd5;
  localparam logic [4:0] ALU_XOR  = 5'd6;
  localparam logic [4:0] ALU_SLL  = 5'd7;
  localparam logic [4:0] ALU_SRL  = 5'd8;
  localparam logic [4:0] ALU_SLTU = 5'd9;
  localparam logic [4:0] ALU_SLLV = 5'd12;
  localparam logic [4:0] ALU_SRA  = 5'd13;
  localparam logic [4:0] ALU_SRAV = 5'd14;
  localparam logic [4:0] ALU_SRLV = 5'd15;
  localparam logic [4:0] ALU_LUI  = 5'd22;
  localparam logic [4:0] ALU_MFLO = 5'd23;
  localparam logic [4:0] ALU_MFHI = 5'd24;
  localparam logic [4:0] ALU_MFC0 = 5'd25;

  localparam logic [1:0] EXT_ZERO  = 2'b00;
  localparam logic [1:0] EXT_SIGN  = 2'b01;
  localparam logic [1:0] EXT_UPPER = 2'b10;

  typedef struct packed {
    logic       regdst;
    logic       regwr;
    logic       alusrc;
    logic       memwr;
    logic       memtoreg;
    logic       branch;
    logic       jump;
    logic [1:0] extop;
    logic [4:0] aluctr;
  } ctrl_t;

  function automatic ctrl_t alu_r(input logic [4:0] code);
    ctrl_t c;
    c        = '0;
    c.regdst = 1'b1;
    c.regwr  = 1'b1;
    c.aluctr = code;
    return c;
  endfunction

  function automatic ctrl_t alu_i(input logic [4:0] code, input logic [1:0] ext);
    ctrl_t c;
    c        = '0;
    c.regwr  = 1'b1;
    c.alusrc = 1'b1;
    c.extop  = ext;
    c.aluctr = code;
    return c;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decoder: control bundle plus illegal / MDU / HI-LO classification.
module ctrl_decode
  import pipe_ctrl_pkg::*;
(
  input  logic [31:0] i_instr,
  output ctrl_t       o_ctrl,
  output logic        o_illegal,
  output logic        o_is_md,
  output logic        o_is_hilo
);

  logic [5:0] w_op;
  logic [4:0] w_rs;
  logic [5:0] w_funct;
  logic       w_unused_mid;

  assign w_op         = i_instr[31:26];
  assign w_rs         = i_instr[25:21];
  assign w_funct      = i_instr[5:0];
  assign w_unused_mid = ^i_instr[20:6];

  always_comb begin
    o_ctrl    = '0;
    o_illegal = 1'b0;
    o_is_md   = 1'b0;
    o_is_hilo = 1'b0;
    case (w_op)
      OP_RTYPE: begin
        case (w_funct)
          F_ADDU: o_ctrl = alu_r(ALU_ADDU);
          F_SUBU: o_ctrl = alu_r(ALU_SUBU);
          F_AND:  o_ctrl = alu_r(ALU_AND);
          F_OR:   o_ctrl = alu_r(ALU_OR);
          F_XOR:  o_ctrl = alu_r(ALU_XOR);
          F_NOR:  o_ctrl = alu_r(ALU_NOR);
          F_SLT:  o_ctrl = alu_r(ALU_SLT);
          F_SLTU: o_ctrl = alu_r(ALU_SLTU);
          F_SLL:  o_ctrl = alu_r(ALU_SLL);
          F_SRL:  o_ctrl = alu_r(ALU_SRL);
          F_SRA:  o_ctrl = alu_r(ALU_SRA);
          F_SLLV: o_ctrl = alu_r(ALU_SLLV);
          F_SRLV: o_ctrl = alu_r(ALU_SRLV);
          F_SRAV: o_ctrl = alu_r(ALU_SRAV);
          F_JR:   o_ctrl.jump = 1'b1;
          F_MFHI: begin
            o_ctrl    = alu_r(ALU_MFHI);
            o_is_hilo = 1'b1;
          end
          F_MFLO: begin
            o_ctrl    = alu_r(ALU_MFLO);
            o_is_hilo = 1'b1;
          end
          // HI/LO writes carry no register-file controls; the MDU datapath handles them
          F_MTHI, F_MTLO: o_is_hilo = 1'b1;
          F_MULT, F_MULTU, F_DIV, F_DIVU: begin
            o_is_md   = 1'b1;
            o_is_hilo = 1'b1;
          end
          default: o_illegal = 1'b1;
        endcase
      end
      OP_ADDIU: o_ctrl = alu_i(ALU_ADDU, EXT_SIGN);
      OP_SLTI:  o_ctrl = alu_i(ALU_SLT,  EXT_SIGN);
      OP_SLTIU: o_ctrl = alu_i(ALU_SLTU, EXT_SIGN);
      OP_ANDI:  o_ctrl = alu_i(ALU_AND,  EXT_ZERO);
      OP_ORI:   o_ctrl = alu_i(ALU_OR,   EXT_ZERO);
      OP_XORI:  o_ctrl = alu_i(ALU_XOR,  EXT_ZERO);
      OP_LUI:   o_ctrl = alu_i(ALU_LUI,  EXT_UPPER);
      OP_LW, OP_LB, OP_LBU: begin
        o_ctrl          = alu_i(ALU_ADDU, EXT_SIGN);
        o_ctrl.memtoreg = 1'b1;
      end
      OP_SW, OP_SB: begin
        o_ctrl        = alu_i(ALU_ADDU, EXT_SIGN);
        o_ctrl.regwr  = 1'b0;
        o_ctrl.memwr  = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        o_ctrl.branch = 1'b1;
        o_ctrl.extop  = EXT_SIGN;
        o_ctrl.aluctr = ALU_SUBU;
      end
      OP_J:   o_ctrl.jump = 1'b1;
      // link register is chosen by the datapath, so regdst stays 0
      OP_JAL: begin
        o_ctrl.jump  = 1'b1;
        o_ctrl.regwr = 1'b1;
      end
      OP_COP0: begin
        if (w_rs == RS_MF) begin
          o_ctrl.regwr  = 1'b1;
          o_ctrl.aluctr = ALU_MFC0;
        end else if (w_rs == RS_MT) begin
          o_ctrl = '0;
        end else if (w_rs == RS_CO && w_funct == F_ERET) begin
          o_ctrl.jump = 1'b1;
        end else begin
          o_illegal = 1'b1;
        end
      end
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Decode-to-execute control pipeline register with load-use / MDU stall and flush handling.
module pipe_ctrl_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int ALUCTR_W = 5,
  parameter int MDU_LAT  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         instr_d,
  input  logic                valid_d,
  input  logic                stall_ext,
  input  logic                flush,
  output logic                stall_d,
  output logic                regdst_e,
  output logic                regwr_e,
  output logic                alusrc_e,
  output logic                memwr_e,
  output logic                memtoreg_e,
  output logic                branch_e,
  output logic                jump_e,
  output logic [1:0]          extop_e,
  output logic [ALUCTR_W-1:0] aluctr_e,
  output logic                valid_e,
  output logic                illegal_e,
  output logic                mdu_busy,
  output logic                md_start
);

  localparam logic [4:0] LAT5 = 5'(MDU_LAT);

  ctrl_t      w_ctrl;
  logic       w_illegal;
  logic       w_is_md;
  logic       w_is_hilo;
  logic       w_mdu_hazard;
  logic       w_adv;
  logic       w_start;

  ctrl_t      r_ctrl;
  logic       r_valid;
  logic       r_illegal;
  logic       r_md_start;
  logic [4:0] r_cnt;

  ctrl_decode u_dec (
    .i_instr   (instr_d),
    .o_ctrl    (w_ctrl),
    .o_illegal (w_illegal),
    .o_is_md   (w_is_md),
    .o_is_hilo (w_is_hilo)
  );

  // The counter may still be nonzero in the first reset cycle; keep it out of stall_d then.
  assign w_mdu_hazard = mdu_busy & w_is_hilo & ~rst;
  assign stall_d      = valid_d & ~flush & (stall_ext | w_mdu_hazard);
  assign w_adv        = valid_d & ~stall_d & ~flush;
  assign w_start      = w_adv & w_is_md;

  // Counter loads on the same edge md_start rises, so an HI/LO consumer directly behind
  // the MDU op already sees mdu_busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctrl     <= '0;
      r_valid    <= 1'b0;
      r_illegal  <= 1'b0;
      r_md_start <= 1'b0;
      r_cnt      <= 5'd0;
    end else begin
      r_ctrl     <= w_adv ? w_ctrl : '0;
      r_valid    <= w_adv;
      r_illegal  <= w_adv & w_illegal;
      r_md_start <= w_start;
      if (w_start)
        r_cnt <= LAT5;
      else if (r_cnt != 5'd0)
        r_cnt <= r_cnt - 5'd1;
    end
  end

  assign regdst_e   = r_ctrl.regdst;
  assign regwr_e    = r_ctrl.regwr;
  assign alusrc_e   = r_ctrl.alusrc;
  assign memwr_e    = r_ctrl.memwr;
  assign memtoreg_e = r_ctrl.memtoreg;
  assign branch_e   = r_ctrl.branch;
  assign jump_e     = r_ctrl.jump;
  assign extop_e    = r_ctrl.extop;
  assign aluctr_e   = ALUCTR_W'(r_ctrl.aluctr);
  assign valid_e    = r_valid;
  assign illegal_e  = r_illegal;
  assign mdu_busy   = (r_cnt != 5'd0);
  assign md_start   = r_md_start;

endmodule

// File: doc/pipe_ctrl_unit.md
PIPE_CTRL_UNIT -- requirements
Module: pipe_ctrl_unit

Interface
REQ-001 Parameter ALUCTR_W, default 5, width of ALU operation code.
REQ-002 Parameter MDU_LAT, default 4 (legal 1..31), cycles the multiply/divide unit stays busy after a start.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 instr_d  input  32  decode-stage instruction word.
REQ-006 valid_d  input  1  instr_d holds a real instruction.
REQ-007 stall_ext  input  1  load-use stall request from the hazard unit.
REQ-008 flush  input  1  kill decode instruction (branch taken / exception).
REQ-009 stall_d  output  1  hold fetch/decode registers this cycle (combinational).
REQ-010 regdst_e, regwr_e, alusrc_e, memwr_e, memtoreg_e, branch_e, jump_e  output  1 each  registered execute-stage controls.
REQ-011 extop_e  output  2  immediate extension: 00 zero, 01 sign, 10 upper (imm<<16).
REQ-012 aluctr_e  output  ALUCTR_W  registered ALU operation.
REQ-013 valid_e, illegal_e  output  1 each  execute slot occupied; execute instruction is a reserved/undecoded opcode.
REQ-014 mdu_busy  output  1  MDU counter nonzero; md_start  output  1  one-cycle pulse when a mult/multu/div/divu advances to execute.

Function
REQ-015 Decode SHALL cover the existing R-type, I-type, branch, jump, load/store and CP0 (mfc0/mtc0/eret) set plus multu, div, divu; every control bit SHALL be a defined 0/1, never X.
REQ-016 ALU codes: ADDU 0, SUBU 1, SLT 2, AND 3, NOR 4, OR 5, XOR 6, SLL 7, SRL 8, SLTU 9, SLLV 12, SRA 13, SRAV 14, SRLV 15, LUI 22, MFLO 23, MFHI 24, MFC0 25; addiu/lw/sw/lb/lbu/sb use ADDU, slti SLT, sltiu SLTU, andi/ori/xori AND/OR/XOR with extop 00.
REQ-017 Undecoded op or funct SHALL produce all-zero controls with illegal flag set.
REQ-018 Advance condition adv = valid_d & ~stall_d & ~flush; on adv, execute registers SHALL load decoded controls and valid_e=1.
REQ-019 When not adv, execute registers SHALL load a bubble: all controls 0, valid_e=0, illegal_e=0.
REQ-020 stall_d = valid_d & ~flush & (stall_ext | mdu_hazard); flush SHALL take priority over any stall.
REQ-021 mdu_hazard = mdu_busy & decode instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
REQ-022 MDU counter (5 bits): on md_start load MDU_LAT; else decrement when nonzero; mdu_busy = counter != 0.
REQ-023 md_start = adv & instruction is mult/multu/div/divu; registered, coincident with valid_e of that instruction.
REQ-024 flush SHALL NOT abort a running MDU count; an MDU instruction killed by flush SHALL NOT start the counter.
REQ-025 Back-to-back: MDU instruction in decode on the cycle the counter reaches 0 from 1 SHALL still stall; it advances the next cycle.
REQ-026 Latency: decode -> execute controls exactly one cycle.

Reset
REQ-027 On rst all execute registers, md_start and counter SHALL be 0; rst SHALL override adv, flush and an active MDU count.
REQ-028 stall_d SHALL be 0 during reset regardless of inputs other than valid_d/stall_ext.

Structure
REQ-029 Opcode/funct/rs constants, ALU code constants and the control-bundle field order SHALL live in shared package pipe_ctrl_pkg.
REQ-030 Combinational decoder SHALL be sub-module ctrl_decode (instr -> control bundle, illegal, is_md, is_hilo); pipe_ctrl_unit holds execute register, stall logic, MDU counter.

Verification
REQ-031 addu after reset: instr_d=0x00221821, valid_d=1 -> next cycle regdst_e=1, regwr_e=1, aluctr_e=0, valid_e=1.
REQ-032 mult then mflo, MDU_LAT=4: md_start pulses once, mdu_busy high 4 cycles, mflo stall_d=1 for those cycles, then advances with aluctr_e=23.
REQ-033 stall_ext=1 with lw in decode -> valid_e=0 and all controls 0 next cycle; lw advances when stall_ext drops.
REQ-034 flush=1 together with stall_ext=1 and mult in decode -> stall_d=0, bubble in execute, md_start=0, counter unchanged.
REQ-035 opcode 0x3F -> illegal_e=1, all other controls 0; rst asserted mid MDU count (counter=2) -> counter 0, mdu_busy=0 next cycle.
